// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-wide data memory responder.
package dmem_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned CntWidth  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    // Index width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte storage: synchronous write, registered read, whole-array clear on reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IdxW  = idx_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic                 re,
    input  logic                 clr,
    input  logic [IdxW-1:0]      index,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem_q [DEPTH];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[index] <= wdata;
        end
    end

    // Read register only loads on a read commit, so it reads zero otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[index];
        end else if (clr) begin
            rdata_q <= '0;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding byte memory responder with fixed latency.
// Optional address range checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int unsigned IdxW = idx_width(DEPTH);

    dmem_state_e          state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic [IdxW-1:0]      index_q, index_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;

    logic accept;
    logic fire;
    logic rsp_done;
    logic addr_bad;
    logic mem_we;
    logic mem_re;

    assign req_ready = (state_q == StIdle) && reset;
    assign rsp_valid = (state_q == StResp) && reset;
    assign busy      = (state_q != StIdle) && reset;

    assign accept   = req_valid && req_ready;
    assign fire     = (state_q == StWait) && (cnt_q == '0);
    assign rsp_done = rsp_valid && rsp_ready;

`ifdef DMEM_ADDR_CHECK_EN
    logic oor_q, oor_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            oor_q <= 1'b0;
        end else begin
            oor_q <= oor_d;
        end
    end

    always_comb begin
        oor_d = oor_q;
        if (accept) begin
            oor_d = (req_addr >= 32'(DEPTH));
        end
    end

    assign addr_bad = oor_q;
    assign rsp_err  = oor_q && rsp_valid;
`else
    // Upper address bits are ignored: addresses alias modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:IdxW];
    assign addr_bad    = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        index_d = index_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    index_d = req_addr[IdxW-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CntWidth'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage is touched only on the WAIT->RESP edge.
    assign mem_we = fire && write_q && !addr_bad;
    assign mem_re = fire && !write_q && !addr_bad;

    dmem_array #(
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .clr   (rsp_done),
        .index (index_q),
        .wdata (wdata_q),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a monitor-driven response scoreboard.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;
`ifdef DMEM_ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t       sb_q[$];
    logic [7:0] model [DEPTH];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         accepts = 0;
    int         acc_cyc = 0;
    int         prev_acc = -1;
    int         idle_cnt = 0;
    bit         prev_valid = 1'b0;
    bit         stream_mode = 1'b0;
    logic [7:0] last_rdata = '0;
    logic       last_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle, pushes model results on accept, pops on handshake.
    always begin
        rsp_t e;
        @(negedge clk);
        #3;
        if (!reset) begin
            sb_q.delete();
            for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid)
                check("latency", 32'(cyc - acc_cyc - 1), 32'(LATENCY));
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
            end
            if (!stream_mode) begin
                prev_acc = -1;
                idle_cnt = 0;
            end else if (!busy) begin
                idle_cnt++;
            end
            if (req_valid && req_ready) begin
                accepts++;
                if (stream_mode && prev_acc >= 0) begin
                    check("accept_gap", 32'(cyc - prev_acc), 32'(LATENCY + 2));
                    check("busy_low_cycles", 32'(idle_cnt), 32'(1));
                end
                idle_cnt = 0;
                prev_acc = cyc;
                acc_cyc  = cyc;
                if (AddrCheck && (req_addr >= 32'(DEPTH))) begin
                    sb_q.push_back('{rdata: 8'h00, err: 1'b1});
                end else if (req_write) begin
                    model[req_addr[7:0]] = req_wdata;
                    sb_q.push_back('{rdata: 8'h00, err: 1'b0});
                end else begin
                    sb_q.push_back('{rdata: model[req_addr[7:0]], err: 1'b0});
                end
            end
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [7:0] d,
                       input int hold, input bit keep_valid);
        int         n;
        int         acc0;
        logic [7:0] first;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("accept_seen", 32'(busy), 32'(1));
        check("wait_rdata_zero", 32'(rsp_rdata), 32'(0));
        check("wait_err_zero", 32'(rsp_err), 32'(0));
        acc0 = accepts;
        if (!keep_valid) req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 32'(rsp_valid), 32'(1));
        first = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'(1));
            check("hold_rdata", 32'(rsp_rdata), 32'(first));
            check("hold_req_ready", 32'(req_ready), 32'(0));
            check("hold_no_accept", 32'(accepts), 32'(acc0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'(0));
        check("post_rdata_zero", 32'(rsp_rdata), 32'(0));
        check("post_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int n;
        int acc0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_err", 32'(rsp_err), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'(1));

        txn(1'b0, 32'h05, 8'h00, 0, 1'b0);
        check("read05_rdata", 32'(last_rdata), 32'(8'h00));
        check("read05_err", 32'(last_err), 32'(0));

        txn(1'b1, 32'h10, 8'hA5, 0, 1'b0);
        txn(1'b0, 32'h10, 8'h00, 0, 1'b0);
        check("read10_rdata", 32'(last_rdata), 32'(8'hA5));

        acc0 = accepts;
        txn(1'b0, 32'h10, 8'h00, 5, 1'b1);
        check("hold_one_accept", 32'(accepts - acc0), 32'(1));
        check("hold_read_rdata", 32'(last_rdata), 32'(8'hA5));

        txn(1'b1, 32'h100, 8'h77, 0, 1'b0);
        check("oor_write_err", 32'(last_err), 32'(AddrCheck));
        txn(1'b0, 32'h00, 8'h00, 0, 1'b0);
        check("alias_read_rdata", 32'(last_rdata), 32'(AddrCheck ? 8'h00 : 8'h77));

        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 8'h3C;
        @(negedge clk);
        check("rstwait_busy", 32'(busy), 32'(1));
        req_valid = 1'b0;
        reset     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("inrst_rsp_valid", 32'(rsp_valid), 32'(0));
            check("inrst_busy", 32'(busy), 32'(0));
            check("inrst_req_ready", 32'(req_ready), 32'(0));
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("postrst_no_rsp", 32'(rsp_valid), 32'(0));
        end
        txn(1'b0, 32'h20, 8'h00, 0, 1'b0);
        check("rstwait_read20", 32'(last_rdata), 32'(8'h00));
        txn(1'b0, 32'h10, 8'h00, 0, 1'b0);
        check("cleared_read10", 32'(last_rdata), 32'(8'h00));

        txn(1'b1, 32'h10, 8'h5A, 0, 1'b0);
        @(negedge clk);
        acc0        = accepts;
        stream_mode = 1'b1;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = 32'h10;
        rsp_ready   = 1'b1;
        repeat (20) @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stream_drained", 32'(busy), 32'(0));
        rsp_ready   = 1'b0;
        stream_mode = 1'b0;
        check("stream_accepts", 32'(accepts - acc0), 32'(20 / (LATENCY + 2)));
        check("stream_rdata", 32'(last_rdata), 32'(8'h5A));

        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
